// File: rtl/xpb_reduce_seq.sv
// xpb_reduce_seq: time-shares one registered xpb table port across all upper-bit segments and accumulates the residues
module xpb_reduce_seq #(
  parameter int NUM_SEGS  = 8,
  parameter int SEG_BITS  = 5,
  parameter int XPB_WIDTH = 1024,
  parameter int ACC_EXTRA = 3,
  parameter int LUT_LAT   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_SEGS*SEG_BITS-1:0]     upper_bits,
  output logic                             busy,
  output logic                             lut_req,
  output logic [$clog2(NUM_SEGS)-1:0]      lut_sel,
  output logic [SEG_BITS-1:0]              lut_addr,
  input  logic [XPB_WIDTH-1:0]             lut_data,
  output logic [XPB_WIDTH+ACC_EXTRA-1:0]   acc_out,
  output logic                             done
);
  localparam int sel_w = $clog2(NUM_SEGS);
  localparam int acc_w = XPB_WIDTH + ACC_EXTRA;
  localparam logic [sel_w-1:0] last_sel = sel_w'(NUM_SEGS - 1);
  localparam logic [LUT_LAT-1:0] low_mask = LUT_LAT'((1 << (LUT_LAT - 1)) - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [NUM_SEGS*SEG_BITS-1:0] shadow;
  logic [LUT_LAT-1:0] vld;
  logic req_n, done_n, accept;
  logic [sel_w-1:0] sel_n;
  logic [SEG_BITS-1:0] addr_n;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    req_n   = 1'b0;
    sel_n   = '0;
    addr_n  = '0;
    done_n  = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_n = ISSUE;
        req_n   = 1'b1;
        addr_n  = upper_bits[SEG_BITS-1:0];
      end
      ISSUE: if (lut_sel == last_sel) state_n = DRAIN;
      else begin
        req_n  = 1'b1;
        sel_n  = lut_sel + 1'b1;
        addr_n = shadow[sel_n*SEG_BITS +: SEG_BITS];
      end
      DRAIN: if ((vld & low_mask) == '0) begin
        state_n = DONE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lut_req  <= 1'b0;
      lut_sel  <= '0;
      lut_addr <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      lut_req  <= req_n;
      lut_sel  <= sel_n;
      lut_addr <= addr_n;
      done     <= done_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      vld     <= '0;
      acc_out <= '0;
    end else begin
      vld     <= LUT_LAT'({vld, lut_req});
      shadow  <= accept ? upper_bits : shadow;
      acc_out <= accept ? '0 : vld[LUT_LAT-1] ? acc_out + acc_w'(lut_data) : acc_out;
    end
  end
endmodule

// File: tb/tb_xpb_reduce_seq.sv
// tb_xpb_reduce_seq: directed/randomized checks of the xpb reduction sequencer at table latencies 1 and 2
module tb_xpb_reduce_seq;
  logic clk = 1'b0;
  logic rst;
  logic start_s [2];
  logic [39:0] ub [2];
  logic busy_w [2];
  logic lut_req_w [2];
  logic done_w [2];
  logic [2:0] sel_w [2];
  logic [4:0] addr_w [2];
  logic [1023:0] data_w [2];
  logic [1026:0] acc_w [2];
  logic [1023:0] p1;
  logic [1023:0] tbl [8][32];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xpb_reduce_seq #(.LUT_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .upper_bits(ub[0]), .busy(busy_w[0]),
    .lut_req(lut_req_w[0]), .lut_sel(sel_w[0]), .lut_addr(addr_w[0]), .lut_data(data_w[0]),
    .acc_out(acc_w[0]), .done(done_w[0])
  );

  xpb_reduce_seq #(.LUT_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .upper_bits(ub[1]), .busy(busy_w[1]),
    .lut_req(lut_req_w[1]), .lut_sel(sel_w[1]), .lut_addr(addr_w[1]), .lut_data(data_w[1]),
    .acc_out(acc_w[1]), .done(done_w[1])
  );

  function automatic logic [1023:0] rnd1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge clk) begin
    data_w[0] <= lut_req_w[0] ? tbl[sel_w[0]][addr_w[0]] : rnd1024();
    p1        <= lut_req_w[1] ? tbl[sel_w[1]][addr_w[1]] : rnd1024();
    data_w[1] <= p1;
  end

  function automatic logic [1026:0] model(input logic [39:0] u);
    logic [1026:0] s = '0;
    for (int i = 0; i < 8; i++) s += 1027'(tbl[i][u[i*5 +: 5]]);
    return s;
  endfunction

  function automatic logic [39:0] rnd40();
    return {8'($urandom), $urandom};
  endfunction

  task automatic chk(input string tag, input logic [1026:0] obs, input logic [1026:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int d, input logic [39:0] u, input logic [1026:0] exp, input bit poke);
    int l = (d == 0) ? 1 : 2;
    start_s[d] = 1'b1;
    ub[d] = u;
    tick();
    start_s[d] = 1'b0;
    for (int j = 0; j <= 8 + l + 1; j++) begin
      if (j < 8) begin
        chk("lut_req", lut_req_w[d], 1'b1);
        chk("lut_sel", sel_w[d], j);
        chk("lut_addr", addr_w[d], u[j*5 +: 5]);
      end else chk("lut_req_off", lut_req_w[d], 1'b0);
      chk("done", done_w[d], j == 8 + l);
      chk("busy", busy_w[d], j <= 8 + l);
      if (j == 8 + l) chk("acc", acc_w[d], exp);
      if (j == 8 + l + 1) chk("acc_hold", acc_w[d], exp);
      if (poke && j == 2) begin
        start_s[d] = 1'b1;
        ub[d] = ~u;
      end
      if (poke && j == 3) start_s[d] = 1'b0;
      if (j < 8 + l + 1) tick();
    end
  endtask

  initial begin
    logic [39:0] u;
    logic [1026:0] e, e_next;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      ub[d] = '0;
    end
    for (int i = 0; i < 8; i++) for (int a = 0; a < 32; a++) tbl[i][a] = '0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy_w[d], 1'b0);
      chk("rst_req", lut_req_w[d], 1'b0);
      chk("rst_sel", sel_w[d], 0);
      chk("rst_addr", addr_w[d], 0);
      chk("rst_done", done_w[d], 1'b0);
      chk("rst_acc", acc_w[d], 0);
    end
    rst = 1'b0;
    tick();
    do_op(0, 40'h0, 1027'd0, 1'b0);
    for (int i = 0; i < 8; i++) for (int a = 0; a < 32; a++) tbl[i][a] = 1024'(a + 32 * i);
    do_op(0, {40{1'b1}}, 1027'd1144, 1'b0);
    do_op(1, {40{1'b1}}, 1027'd1144, 1'b0);
    for (int i = 0; i < 8; i++) for (int a = 0; a < 32; a++) tbl[i][a] = {1024{1'b1}};
    do_op(0, rnd40(), 1027'({1024{1'b1}}) << 3, 1'b0);
    for (int i = 0; i < 8; i++) for (int a = 0; a < 32; a++) tbl[i][a] = (a == 0) ? '0 : rnd1024();
    u = rnd40();
    do_op(0, u, model(u), 1'b1);
    u = rnd40() & 40'hFF_FFE0_7C1F;
    do_op(1, u, model(u), 1'b1);
    u = rnd40();
    start_s[0] = 1'b1;
    ub[0] = u;
    tick();
    start_s[0] = 1'b0;
    repeat (3) tick();
    chk("mid_req", lut_req_w[0], 1'b1);
    chk("mid_sel", sel_w[0], 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_req", lut_req_w[0], 1'b0);
    chk("abort_sel", sel_w[0], 0);
    chk("abort_addr", addr_w[0], 0);
    chk("abort_done", done_w[0], 1'b0);
    chk("abort_acc", acc_w[0], 0);
    for (int j = 0; j < 15; j++) begin
      chk("abort_no_done", done_w[0], 1'b0);
      chk("abort_idle", busy_w[0], 1'b0);
      tick();
    end
    u = rnd40();
    do_op(0, u, model(u), 1'b0);
    u = rnd40();
    e = model(u);
    ub[1] = u;
    start_s[1] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int j = 1; j <= 10; j++) begin
        tick();
        if (j < 10) chk("held_no_done", done_w[1], 1'b0);
        else begin
          chk("held_done", done_w[1], 1'b1);
          chk("held_acc", acc_w[1], e);
        end
      end
      u = rnd40();
      e_next = model(u);
      ub[1] = u;
      tick();
      chk("held_idle", busy_w[1], 1'b0);
      chk("held_acc_hold", acc_w[1], e);
      tick();
      chk("held_accept", busy_w[1], 1'b1);
      chk("held_req", lut_req_w[1], 1'b1);
      e = e_next;
    end
    start_s[1] = 1'b0;
    repeat (12) tick();
    chk("held_last_acc", acc_w[1], e);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
